// File: rtl/serial_parity_checker_pkg.sv
// Shared types and defaults for the serial parity checker slice.
// FSM state encoding keeps the original numeric values (IDLE=0, DATA=1, PARITY=2).
package serial_parity_checker_pkg;

    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial bit stream in, parallel word and parity result out.
// master = frame source / result consumer, slave = the checker.
interface serial_parity_checker_if
    import serial_parity_checker_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              start;
    logic              bit_in;
    logic              bit_valid;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              parity_err;
    logic              frame_done;

    modport master (
        output start,
        output bit_in,
        output bit_valid,
        input  busy,
        input  data_out,
        input  parity_err,
        input  frame_done
    );

    modport slave (
        input  start,
        input  bit_in,
        input  bit_valid,
        output busy,
        output data_out,
        output parity_err,
        output frame_done
    );

endinterface

// File: rtl/serial_parity_checker_parity_accum.sv
// 1-bit running-XOR accumulator with synchronous clear and enable.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    // clear wins over enable; otherwise fold the new bit into the running XOR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity checker: DATA_W data bits LSB first, then one parity bit.
// Reassembles the word, checks parity and pulses frame_done with the result.
// Build option: define SERIAL_PARITY_ODD_EN to expect odd instead of even parity.
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_parity_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic                busy_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   data_out_q;
    logic                parity_err_q;
    logic                frame_done_q;
    logic                acc_q;
    logic                acc_clr;
    logic                data_take;
    logic                done_d;
    logic                parity_res;

    parity_accum u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (data_take),
        .d     (bus.bit_in),
        .q     (acc_q)
    );

    // next-state decode and per-cycle strobes
    always_comb begin
        state_d   = state_q;
        acc_clr   = 1'b0;
        data_take = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DATA;
                    acc_clr = 1'b1;
                end
            end
            DATA: begin
                if (bus.bit_valid) begin
                    data_take = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bus.bit_valid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SERIAL_PARITY_ODD_EN
    assign parity_res = ~(acc_q ^ bus.bit_in);
`else
    assign parity_res = acc_q ^ bus.bit_in;
`endif

    // state register; busy is registered from the next state so it drops with frame_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // bit counter and deserialiser; counter holds at the last bit instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            if (acc_clr) begin
                cnt_q <= '0;
            end else if (data_take) begin
                shift_q <= {bus.bit_in, shift_q[DATA_W-1:1]};
                if (cnt_q != LAST_BIT) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // result registers, updated together with a one-cycle frame_done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= done_d;
            if (done_d) begin
                data_out_q   <= shift_q;
                parity_err_q <= parity_res;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.data_out   = data_out_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_done = frame_done_q;

endmodule
